// File: rtl/mlp_axis_pkg.sv
// Shared types and helpers for the MLP AXI-Stream output path.
// Entry layout, pointer sizing and strobe constant.
package mlp_axis_pkg;

  localparam int DEF_DATA_W = 32;

  localparam logic [127:0] STRB_ALL = '1;

  typedef struct packed {
    logic                  last;
    logic [DEF_DATA_W-1:0] data;
  } axis_entry_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/axis_master_pkt_fifo_if.sv
// AXI-Stream bundle between the packet FIFO and the DMA.
// Master drives payload, slave drives ready.
interface axis_master_pkt_fifo_if #(
  parameter int W = 32
) ();

  logic           tvalid;
  logic [W-1:0]   tdata;
  logic [W/8-1:0] tstrb;
  logic           tlast;
  logic           tready;

  modport master (
    output tvalid, tdata, tstrb, tlast,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tlast,
    output tready
  );

endinterface

// File: rtl/mlp_sync_fifo.sv
// Generic first-word-fall-through FIFO with occupancy count.
// Reads return zero while empty so the head is clean after reset.
module mlp_sync_fifo
  import mlp_axis_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16,
  localparam int PW   = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [PW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             wr;
  logic             rd;

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign rdata = empty ? '0 : mem[rptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= wdata;
  end

  // Pointers and occupancy; pointers wrap at the power-of-2 depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr) wptr <= wptr + PW'(1);
      if (rd) rptr <= rptr + PW'(1);
      count <= count + (PW+1)'(wr) - (PW+1)'(rd);
    end
  end

endmodule

// File: rtl/axis_master_pkt_fifo.sv
// MLP result stream master: FIFO-buffered beats with TLAST framing.
// Length is latched per packet and TLAST is stored with each beat.
module axis_master_pkt_fifo
  import mlp_axis_pkg::*;
#(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH           = 16,
  parameter int LEN_WIDTH            = 10
) (
  input  logic                            M_AXIS_ACLK,
  input  logic                            M_AXIS_ARESETN,
  input  logic [LEN_WIDTH-1:0]            pi_current_layer_nodes,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0] pi_mlp_data,
  input  logic                            pi_write_to_fifo,
  input  logic                            pi_clear_overflow,
  output logic                            po_fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]     po_fifo_level,
  output logic                            po_overflow,
  output logic                            po_wr_fifo_done,
  axis_master_pkt_fifo_if.master          m_axis
);

  localparam int W = C_M_AXIS_TDATA_WIDTH;

  typedef struct packed {
    logic         last;
    logic [W-1:0] data;
  } entry_t;

  entry_t               wr_e;
  entry_t               rd_e;
  logic                 empty;
  logic                 push_ok;
  logic                 pop;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] wcnt;
  logic [LEN_WIDTH-1:0] len_in;
  logic [LEN_WIDTH-1:0] eff_len;
  logic [LEN_WIDTH:0]   beat_n;
  logic                 is_last;

  assign push_ok = pi_write_to_fifo && !po_fifo_full;
  assign pop     = !empty && m_axis.tready;

  // A zero length would never close a packet, so it means one beat.
  assign len_in  = (pi_current_layer_nodes == '0) ?
                   LEN_WIDTH'(1) : pi_current_layer_nodes;
  assign eff_len = (wcnt == '0) ? len_in : len_q;
  assign beat_n  = {1'b0, wcnt} + (LEN_WIDTH+1)'(1);
  assign is_last = (beat_n == {1'b0, eff_len});
  assign wr_e    = '{last: is_last, data: pi_mlp_data};

  mlp_sync_fifo #(
    .WIDTH (W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (M_AXIS_ACLK),
    .rst_n (M_AXIS_ARESETN),
    .push  (push_ok),
    .wdata (wr_e),
    .pop   (pop),
    .rdata (rd_e),
    .count (po_fifo_level),
    .full  (po_fifo_full),
    .empty (empty)
  );

  assign m_axis.tvalid = !empty;
  assign m_axis.tdata  = rd_e.data;
  assign m_axis.tlast  = rd_e.last;
  assign m_axis.tstrb  = STRB_ALL[W/8-1:0];

  // Packet framing: latch length on the first beat, wrap after the last.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      len_q <= LEN_WIDTH'(1);
      wcnt  <= '0;
    end else if (push_ok) begin
      if (wcnt == '0) len_q <= len_in;
      wcnt <= is_last ? '0 : beat_n[LEN_WIDTH-1:0];
    end
  end

  // Sticky drop flag; a new drop outranks a clear in the same cycle.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      po_overflow <= 1'b0;
    end else if (pi_write_to_fifo && po_fifo_full) begin
      po_overflow <= 1'b1;
    end else if (pi_clear_overflow) begin
      po_overflow <= 1'b0;
    end
  end

  // One-cycle done pulse after each packet-closing handshake.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) po_wr_fifo_done <= 1'b0;
    else                 po_wr_fifo_done <= pop && rd_e.last;
  end

endmodule
